// File: rtl/match_pkg.sv
// match_pkg: game states, action indices and the PS/2 key map shared by the match controller
package match_pkg;

    typedef enum logic [2:0] {
        S_MAIN  = 3'd0,
        S_IDLE  = 3'd1,
        S_RUN   = 3'd2,
        S_PAUSE = 3'd3,
        S_END   = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        A_UP    = 3'd0,
        A_DOWN  = 3'd1,
        A_LEFT  = 3'd2,
        A_RIGHT = 3'd3,
        A_BOOM  = 3'd4
    } act_t;

    localparam int NACT = 5;

    localparam logic [8:0] K_SPACE = 9'h029;
    localparam logic [8:0] K_P     = 9'h04D;
    localparam logic [8:0] K_R     = 9'h02D;

    // {ext, code} per player, ordered up, down, left, right, boom
    localparam logic [0:19][8:0] KEYMAP = {
        9'h01D, 9'h01B, 9'h01C, 9'h023, 9'h016,
        9'h175, 9'h172, 9'h16B, 9'h174, 9'h069,
        9'h043, 9'h042, 9'h03B, 9'h04B, 9'h03A,
        9'h075, 9'h073, 9'h06B, 9'h074, 9'h070
    };

endpackage

// File: rtl/match_ctrl_if.sv
// match_ctrl_if: key/fail inputs and game status/action outputs of the match controller
interface match_ctrl_if #(
    parameter int NPLAYERS = 2,
    parameter int TIME_W   = 16
);
    logic [10:0]         key_event;
    logic [NPLAYERS-1:0] fail;
    logic [2:0]          state;
    logic                running;
    logic                frozen;
    logic                help;
    logic                game_rst;
    logic [TIME_W-1:0]   time_left;
    logic [3:0]          swap_left;
    logic [1:0]          level;
    logic [NPLAYERS-1:0] act_up;
    logic [NPLAYERS-1:0] act_down;
    logic [NPLAYERS-1:0] act_left;
    logic [NPLAYERS-1:0] act_right;
    logic [NPLAYERS-1:0] act_boom;

    modport master (
        output key_event, fail,
        input  state, running, frozen, help, game_rst, time_left, swap_left, level,
        input  act_up, act_down, act_left, act_right, act_boom
    );

    modport slave (
        input  key_event, fail,
        output state, running, frozen, help, game_rst, time_left, swap_left, level,
        output act_up, act_down, act_left, act_right, act_boom
    );
endinterface

// File: rtl/key_repeat.sv
// key_repeat: held bit and make-edge pulse for one mapped key; AUTOREPEAT_EN adds a held-key repeat counter
module key_repeat
`ifdef AUTOREPEAT_EN
#(
    parameter bit REP        = 1'b0,
    parameter int REPEAT_DLY = 20,
    parameter int REPEAT_PER = 5
)
`endif
(
    input  logic clk,
    input  logic rstn,
    input  logic clr,
    input  logic hit,
    input  logic brk,
`ifdef AUTOREPEAT_EN
    input  logic run,
    input  logic sub_tick,
`endif
    output logic pulse
);
    logic held, rise;

    assign rise = hit && !brk && !held;

    // held follows make/break so typematic makes do not re-trigger; game reset drops it
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) held <= 1'b0;
        else if (clr) held <= 1'b0;
        else if (hit) held <= !brk;

`ifdef AUTOREPEAT_EN
    logic [7:0] cnt;
    logic       fire;

    assign fire = REP && run && held && sub_tick && cnt == 8'(REPEAT_DLY - 1);

    // sub-ticks since the make; after each repeat it restarts REPEAT_PER short of the delay
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) cnt <= '0;
        else if (clr || rise || !held || !run) cnt <= '0;
        else if (REP && sub_tick) cnt <= fire ? 8'(REPEAT_DLY - REPEAT_PER) : cnt + 8'd1;

    // one-cycle pulse on the make edge or on a repeat
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) pulse <= 1'b0;
        else pulse <= !clr && (rise || fire);
`else
    // one-cycle pulse on the make edge only
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) pulse <= 1'b0;
        else pulse <= rise;
`endif

endmodule

// File: rtl/match_ctrl.sv
// match_ctrl: PS/2 key decode into per-player action pulses, game-flow FSM, countdown, level and swap window
// (AUTOREPEAT_EN enables held-key auto-repeat of left/right/down)
module match_ctrl
    import match_pkg::*;
#(
    parameter int NPLAYERS    = 2,
    parameter int TICK_DIV    = 100_000_000,
    parameter int TIME_W      = 16,
    parameter int PRESET_DEF  = 180,
    parameter int PRESET_STEP = 30,
    parameter int PRESET_MAX  = 600,
    parameter int SWAP_PERIOD = 60,
    parameter int SWAP_LEN    = 5,
    parameter int LEVEL_SEC   = 60,
    parameter int NLEVELS     = 3,
    parameter int REPEAT_DLY  = 20,
    parameter int REPEAT_PER  = 5
) (
    input logic         clk,
    input logic         rstn,
    match_ctrl_if.slave bus
);
    localparam int TW = $clog2(TICK_DIV);

    state_t              state, state_n;
    logic [TIME_W-1:0]   preset, preset_n, time_left, sw_cnt, lv_cnt;
    logic [3:0]          swap_left;
    logic [1:0]          level;
    logic [TW-1:0]       tick_cnt;
    logic                tick, running, frozen, game_rst;
    logic                kv, kb, sp, pz, rr, up_e, dn_e, sw_w, lv_w;
    logic [8:0]          kc;
    logic [2:0]          g_hit, g_held;
    logic [NPLAYERS-1:0] pl  [NACT];
    logic [NPLAYERS-1:0] act [NACT];

    assign kv = bus.key_event[10];
    assign kb = bus.key_event[8];
    assign kc = {bus.key_event[9], bus.key_event[7:0]};

    assign g_hit          = {3{kv}} & {kc == K_R, kc == K_P, kc == K_SPACE};
    assign {rr, pz, sp}   = g_hit & ~g_held & {3{!kb}};

    assign running = state == S_RUN;
    assign frozen  = state == S_RUN || state == S_PAUSE || state == S_END;
    assign tick    = running && tick_cnt == TW'(TICK_DIV - 1);
    assign sw_w    = sw_cnt == TIME_W'(SWAP_PERIOD - 1);
    assign lv_w    = lv_cnt == TIME_W'(LEVEL_SEC - 1);

`ifdef AUTOREPEAT_EN
    localparam int SUB_DIV = TICK_DIV >= 100 ? TICK_DIV / 100 : 1;
    localparam int SW      = $clog2(SUB_DIV + 1);

    logic [SW-1:0] sub_cnt;
    logic          sub_tick;

    assign sub_tick = running && sub_cnt == SW'(SUB_DIV - 1);

    // 10 ms sub-tick divider for auto-repeat, running only in RUN
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) sub_cnt <= '0;
        else if (rr || !running) sub_cnt <= '0;
        else sub_cnt <= sub_tick ? '0 : sub_cnt + SW'(1);
`endif

    for (genvar p = 0; p < NPLAYERS; p++) begin : g_p
        for (genvar a = 0; a < NACT; a++) begin : g_a
            localparam logic [8:0] KC = KEYMAP[p * NACT + a];
            key_repeat
`ifdef AUTOREPEAT_EN
                #(.REP(a == int'(A_LEFT) || a == int'(A_RIGHT) || a == int'(A_DOWN)),
                  .REPEAT_DLY(REPEAT_DLY), .REPEAT_PER(REPEAT_PER))
`endif
            u_key (
                .clk(clk),
                .rstn(rstn),
                .clr(rr),
                .hit(kv && kc == KC),
                .brk(kb),
`ifdef AUTOREPEAT_EN
                .run(running),
                .sub_tick(sub_tick),
`endif
                .pulse(pl[a][p])
            );
        end
    end

    // during a swap window player i's actions land on player i+1
    for (genvar a = 0; a < NACT; a++) begin : g_act
        assign act[a] = !running ? '0 :
                        swap_left != '0 ? {pl[a][NPLAYERS-2:0], pl[a][NPLAYERS-1]} : pl[a];
    end

    assign up_e     = pl[A_UP][0] | pl[A_UP][1];
    assign dn_e     = pl[A_DOWN][0] | pl[A_DOWN][1];
    assign preset_n = up_e ? (preset > TIME_W'(PRESET_MAX - PRESET_STEP) ? TIME_W'(PRESET_MAX)
                                                                         : preset + TIME_W'(PRESET_STEP)) :
                      dn_e ? (preset <= TIME_W'(PRESET_STEP) ? TIME_W'(PRESET_STEP)
                                                             : preset - TIME_W'(PRESET_STEP)) :
                      preset;

    // game keys get their own held bits so typematic space/P/R act once
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) g_held <= '0;
        else if (rr) g_held <= '0;
        else g_held <= (g_held & ~g_hit) | (g_hit & {3{!kb}});

    // game-flow next state; a top-out or expired clock beats a same-cycle pause
    always_comb begin
        state_n = state;
        case (state)
            S_MAIN:  state_n = sp ? S_IDLE : S_MAIN;
            S_IDLE:  state_n = (sp && time_left != '0) ? S_RUN : S_IDLE;
            S_RUN:   state_n = (|bus.fail || time_left == '0) ? S_END : pz ? S_PAUSE : S_RUN;
            S_PAUSE: state_n = sp ? S_RUN : S_PAUSE;
            default: state_n = state;
        endcase
        if (rr) state_n = S_MAIN;
    end

    // game state register
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) state <= S_MAIN;
        else state <= state_n;

    // 1 s tick divider; pausing holds the partial count
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) tick_cnt <= '0;
        else if (rr) tick_cnt <= '0;
        else if (running) tick_cnt <= tick ? '0 : tick_cnt + TW'(1);

    // preset editing while unfrozen, then countdown, swap window and level on each run tick
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) begin
            preset    <= TIME_W'(PRESET_DEF);
            time_left <= TIME_W'(PRESET_DEF);
            swap_left <= '0;
            level     <= '0;
            sw_cnt    <= '0;
            lv_cnt    <= '0;
        end else if (rr) begin
            time_left <= preset;
            swap_left <= '0;
            level     <= '0;
            sw_cnt    <= '0;
            lv_cnt    <= '0;
        end else if (!frozen) begin
            preset    <= preset_n;
            time_left <= preset_n;
        end else if (tick) begin
            time_left <= time_left - TIME_W'(time_left != '0);
            sw_cnt    <= sw_w ? '0 : sw_cnt + TIME_W'(1);
            lv_cnt    <= lv_w ? '0 : lv_cnt + TIME_W'(1);
            swap_left <= sw_w ? 4'(SWAP_LEN) : swap_left - 4'(swap_left != '0);
            level     <= (lv_w && level != 2'(NLEVELS - 1)) ? level + 2'd1 : level;
        end

    // one-cycle game reset pulse on the R make
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) game_rst <= 1'b0;
        else game_rst <= rr;

    assign bus.state     = state;
    assign bus.running   = running;
    assign bus.frozen    = frozen;
    assign bus.help      = state == S_MAIN || state == S_PAUSE;
    assign bus.game_rst  = game_rst;
    assign bus.time_left = time_left;
    assign bus.swap_left = swap_left;
    assign bus.level     = level;
    assign bus.act_up    = act[A_UP];
    assign bus.act_down  = act[A_DOWN];
    assign bus.act_left  = act[A_LEFT];
    assign bus.act_right = act[A_RIGHT];
    assign bus.act_boom  = act[A_BOOM];

endmodule

// File: tb/tb_match_ctrl.sv
// tb_match_ctrl: directed checks of match_ctrl game flow, preset editing, countdown, swap and reset
module tb_match_ctrl;
    localparam int TD = 20;

    logic clk = 1'b0;
    logic rstn;
    int   n_chk = 0;
    int   n_fail = 0;
    int   pulses;

    match_ctrl_if #(.NPLAYERS(2), .TIME_W(16)) bus ();

    match_ctrl #(.NPLAYERS(2), .TICK_DIV(TD)) dut (
        .clk(clk),
        .rstn(rstn),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic ext, input logic brk, input logic [7:0] code);
        bus.key_event = {1'b1, ext, brk, code};
        @(negedge clk);
        bus.key_event = '0;
    endtask

    task automatic press(input logic ext, input logic [7:0] code, input int n);
        for (int i = 0; i < n; i++) begin
            send(ext, 1'b0, code);
            send(ext, 1'b1, code);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        bus.key_event = '0;
        bus.fail = '0;
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        chk("rst_state", bus.state, 0);
        chk("rst_time", bus.time_left, 180);
        chk("rst_swap", bus.swap_left, 0);
        chk("rst_level", bus.level, 0);
        chk("rst_act", bus.act_up, 0);
        chk("rst_grst", bus.game_rst, 0);
        chk("rst_help", bus.help, 1);
        chk("rst_frozen", bus.frozen, 0);

        send(0, 0, 8'h29);
        chk("main_to_idle", bus.state, 1);
        send(0, 1, 8'h29);
        send(0, 0, 8'h1D);
        chk("idle_act_gated", bus.act_up, 0);
        send(0, 1, 8'h1D);
        press(0, 8'h1D, 2);
        chk("preset_270", bus.time_left, 270);
        press(0, 8'h1D, 17);
        chk("preset_max", bus.time_left, 600);
        press(0, 8'h1B, 25);
        chk("preset_min", bus.time_left, 30);
        press(0, 8'h1D, 6);
        chk("preset_210", bus.time_left, 210);

        send(0, 0, 8'h29);
        chk("idle_to_run", bus.state, 2);
        chk("run_running", bus.running, 1);
        chk("run_frozen", bus.frozen, 1);
        send(0, 1, 8'h29);
        wait_cyc(TD);
        chk("tick1", bus.time_left, 209);
        wait_cyc(TD);
        chk("tick2", bus.time_left, 208);
        wait_cyc(58 * TD);
        chk("swap_load", bus.swap_left, 5);
        chk("level_1", bus.level, 1);
        chk("time_150", bus.time_left, 150);
        send(0, 0, 8'h1D);
        chk("swap_route", bus.act_up, 2'b10);
        send(0, 1, 8'h1D);
        wait_cyc(5 * TD);
        chk("swap_end", bus.swap_left, 0);
        send(0, 0, 8'h1D);
        chk("no_swap_route", bus.act_up, 2'b01);
        send(0, 1, 8'h1D);

        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            send(1, 0, 8'h75);
            pulses += int'(bus.act_up[1]);
        end
        send(1, 1, 8'h75);
        pulses += int'(bus.act_up[1]);
        chk("typematic_once", pulses, 1);
        send(0, 0, 8'h16);
        chk("boom_p0", bus.act_boom, 2'b01);
        send(0, 1, 8'h16);
        send(0, 0, 8'h70);
        chk("p3_ignored", bus.act_boom, 2'b00);
        send(0, 1, 8'h70);
        send(0, 0, 8'h43);
        chk("p2_ignored", bus.act_up, 2'b00);
        send(0, 1, 8'h43);

        send(0, 0, 8'h4D);
        chk("run_to_pause", bus.state, 3);
        chk("pause_help", bus.help, 1);
        send(0, 1, 8'h4D);
        send(0, 0, 8'h1D);
        chk("pause_act_gated", bus.act_up, 0);
        send(0, 1, 8'h1D);
        wait_cyc(5 * TD);
        chk("pause_frozen_time", bus.time_left, 145);
        send(0, 0, 8'h29);
        chk("pause_to_run", bus.state, 2);
        send(0, 1, 8'h29);
        chk("resume_time", bus.time_left, 145);
        wait_cyc(2);
        chk("resume_partial", bus.time_left, 144);

        bus.fail = 2'b10;
        send(0, 0, 8'h4D);
        bus.fail = '0;
        chk("fail_beats_pause", bus.state, 4);
        chk("end_running", bus.running, 0);
        send(0, 1, 8'h4D);
        send(0, 0, 8'h29);
        chk("end_terminal", bus.state, 4);
        send(0, 1, 8'h29);

        send(0, 0, 8'h2D);
        chk("grst_pulse", bus.game_rst, 1);
        chk("grst_state", bus.state, 0);
        chk("grst_preset_kept", bus.time_left, 210);
        chk("grst_level", bus.level, 0);
        send(0, 1, 8'h2D);
        chk("grst_one_cycle", bus.game_rst, 0);

        press(0, 8'h29, 1);
        press(0, 8'h1B, 6);
        chk("preset_30", bus.time_left, 30);
        send(0, 0, 8'h29);
        chk("run2", bus.state, 2);
        send(0, 1, 8'h29);
        wait_cyc(30 * TD - 2);
        chk("timeout_t1", bus.time_left, 1);
        wait_cyc(1);
        chk("timeout_t0", bus.time_left, 0);
        chk("timeout_still_run", bus.state, 2);
        wait_cyc(1);
        chk("timeout_end", bus.state, 4);
        chk("timeout_swap", bus.swap_left, 0);
        chk("timeout_level", bus.level, 0);

        press(0, 8'h2D, 1);
        press(0, 8'h29, 1);
        send(0, 0, 8'h29);
        send(0, 1, 8'h29);
        chk("run3", bus.state, 2);
        wait_cyc(10);
        #3 rstn = 1'b0;
        #1;
        chk("async_state", bus.state, 0);
        chk("async_time", bus.time_left, 180);
        chk("async_running", bus.running, 0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        chk("post_reset_state", bus.state, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
